vst_drain_queue: RTL and testbench

//  Memory-side reader for the sequencer's vector-store path.
//  - Accepts the 128-bit st_data beats the sequencer emits for one vector-register store.
//  - Buffers them in a DEPTH-entry FIFO.
//  - Drains them to memory over a req/ack write port at consecutive addresses.
//  - Pulses s_done back to the sequencer once every beat of the store has been accepted by memory.

---
 rtl/vst_drain_queue.sv | 144 ++++++++++++++
 tb/tb_vst_drain_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vst_drain_queue.sv
// rtl/vst_drain_queue.sv - vector-store drain queue: beat FIFO feeding a req/ack memory write port
module vst_drain_queue #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 10,
    parameter int ADDR_W = 32,
    parameter int BEATS  = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              st_start,
    input  logic [ADDR_W-1:0] st_base,
    input  logic              st_valid,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              s_done,
    output logic              err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BC_W  = $clog2(BEATS + 1);

    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [BC_W-1:0]   BEATS_C    = BC_W'(BEATS);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BC_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BC_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   fifo_q [DEPTH];
    logic [DATA_W-1:0]   fifo_d [DEPTH];
    logic                err_q, err_d;
    logic                push, pop;

    // State register; reset aborts any store in flight
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: FIFO storage, pointers, beat counters, base and sticky error
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            base_q   <= '0;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fifo_q   <= '{default: '0};
            err_q    <= 1'b0;
        end else begin
            base_q   <= base_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
            err_q    <= err_d;
        end
    end

    // Next state; uses next-cycle counters so s_done lands one cycle after the final ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (st_start) state_d = S_FILL;
            S_FILL: begin
                if (tx_cnt_d == BEATS_C)      state_d = S_DONE;
                else if (rx_cnt_d == BEATS_C) state_d = S_DRAIN;
            end
            S_DRAIN: if (tx_cnt_d == BEATS_C) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs depend on registered state only, never on mem_ack or st_valid
    always_comb begin
        st_ready = (state_q == S_FILL) && (count_q < CNT_FULL) && (rx_cnt_q < BEATS_C);
        mem_req  = ((state_q == S_FILL) || (state_q == S_DRAIN)) && (count_q != '0);
        busy     = (state_q != S_IDLE);
        s_done   = (state_q == S_DONE);
    end

    assign mem_addr  = base_q + ADDR_W'(tx_cnt_q) * BEAT_BYTES;
    assign mem_wdata = fifo_q[rd_ptr_q];
    assign err       = err_q;
    assign push      = st_valid && st_ready;
    assign pop       = mem_req && mem_ack;

    // FIFO push/pop, explicit pointer wrap for non-power-of-2 depth, counter updates
    always_comb begin
        base_d   = base_q;
        rx_cnt_d = rx_cnt_q;
        tx_cnt_d = tx_cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fifo_d   = fifo_q;
        err_d    = err_q | (st_valid && !st_ready);

        if ((state_q == S_IDLE) && st_start) begin
            base_d   = st_base;
            rx_cnt_d = '0;
            tx_cnt_d = '0;
        end
        if (push) begin
            fifo_d[wr_ptr_q] = st_data;
            wr_ptr_d         = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            rx_cnt_d         = rx_cnt_q + BC_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            tx_cnt_d = tx_cnt_q + BC_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

endmodule

// File: tb/tb_vst_drain_queue.sv
// tb/tb_vst_drain_queue.sv - randomized self-checking bench for vst_drain_queue
module tb_vst_drain_queue;

    localparam int DW    = 128;
    localparam int AW    = 32;
    localparam int DEPTH = 10;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          st_start = 1'b0;
    logic [AW-1:0] st_base = '0;
    logic          st_valid = 1'b0;
    logic [DW-1:0] st_data = '0;
    logic          mem_ack = 1'b0;

    logic          st_ready8, mem_req8, busy8, s_done8, err8;
    logic [AW-1:0] mem_addr8;
    logic [DW-1:0] mem_wdata8;
    logic          st_ready16, mem_req16, busy16, s_done16, err16;
    logic [AW-1:0] mem_addr16;
    logic [DW-1:0] mem_wdata16;

    bit            sel = 1'b0;
    logic          st_ready, mem_req, busy, s_done, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    bit err_exp  = 1'b0;

    vst_drain_queue #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BEATS(8)) dut8 (
        .clk(clk), .nrst(nrst), .st_start(st_start), .st_base(st_base),
        .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready8),
        .mem_req(mem_req8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
        .mem_ack(mem_ack), .busy(busy8), .s_done(s_done8), .err(err8)
    );

    vst_drain_queue #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BEATS(16)) dut16 (
        .clk(clk), .nrst(nrst), .st_start(st_start), .st_base(st_base),
        .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready16),
        .mem_req(mem_req16), .mem_addr(mem_addr16), .mem_wdata(mem_wdata16),
        .mem_ack(mem_ack), .busy(busy16), .s_done(s_done16), .err(err16)
    );

    assign st_ready  = sel ? st_ready16  : st_ready8;
    assign mem_req   = sel ? mem_req16   : mem_req8;
    assign busy      = sel ? busy16      : busy8;
    assign s_done    = sel ? s_done16    : s_done8;
    assign err       = sel ? err16       : err8;
    assign mem_addr  = sel ? mem_addr16  : mem_addr8;
    assign mem_wdata = sel ? mem_wdata16 : mem_wdata8;

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        nrst = 1'b1; st_valid = 1'b0; st_start = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
    endtask

    // One store: sequencer offers beats, memory acks randomly; all expectations come from
    // beat/write counts: ready = beats left && room, req = beats outstanding, addr = base + 16*k.
    task automatic run_store(input logic [AW-1:0] base, input int nb, input int vpct,
                             input int apct, input int ack_off, input int hold_idx,
                             input int extra, input int abort_at, input string tag);
        logic [DW-1:0] d [16];
        logic [AW-1:0] pa, ea;
        logic [DW-1:0] pd;
        int acc, wr, outst, cyc, hold, extra_left;
        bit fin, exp_ready, exp_req, push, pop, stall;
        for (int i = 0; i < 16; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
        acc = 0; wr = 0; outst = 0; cyc = 0; hold = 0; extra_left = extra;
        fin = 1'b0; stall = 1'b0; pa = '0; pd = '0;
        @(negedge clk);
        st_base = base; st_start = 1'b1;
        @(negedge clk);
        st_start = 1'b0;
        while (!fin && cyc < 600) begin
            exp_ready = (acc < nb) && (outst < DEPTH);
            exp_req   = (outst > 0);
            if (wr == nb) begin
                st_valid = 1'b0; mem_ack = 1'b0;
                #1;
                n_checks++; if (s_done !== 1'b1) begin n_fail++; $display("FAIL %s s_done_pulse: got %b want 1", tag, s_done); end
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_in_done: got %b want 1", tag, busy); end
                n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s req_in_done: got %b want 0", tag, mem_req); end
                n_checks++; if (err !== err_exp) begin n_fail++; $display("FAIL %s err_end: got %b want %b", tag, err, err_exp); end
                @(negedge clk); #1;
                n_checks++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL %s s_done_width: got %b want 0", tag, s_done); end
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_done: got %b want 0", tag, busy); end
                fin = 1'b1;
            end else begin
                if (acc < nb) begin
                    st_valid = ($urandom_range(99) < vpct) && exp_ready;
                    st_data  = d[acc];
                end else if (extra_left > 0) begin
                    st_valid = 1'b1;
                    st_data  = {$urandom, $urandom, $urandom, $urandom};
                    extra_left--;
                end else begin
                    st_valid = 1'b0;
                end
                if (cyc < ack_off) mem_ack = 1'b0;
                else if (exp_req && wr == hold_idx && hold < 5) begin mem_ack = 1'b0; hold++; end
                else mem_ack = ($urandom_range(99) < apct);
                #1;
                n_checks++; if (st_ready !== exp_ready) begin n_fail++; $display("FAIL %s st_ready cyc %0d: got %b want %b", tag, cyc, st_ready, exp_ready); end
                n_checks++; if (mem_req !== exp_req) begin n_fail++; $display("FAIL %s mem_req cyc %0d: got %b want %b", tag, cyc, mem_req, exp_req); end
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy cyc %0d: got %b want 1", tag, cyc, busy); end
                n_checks++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL %s early_s_done cyc %0d: got %b want 0", tag, cyc, s_done); end
                n_checks++; if (err !== err_exp) begin n_fail++; $display("FAIL %s err cyc %0d: got %b want %b", tag, cyc, err, err_exp); end
                if (exp_req) begin
                    ea = base + AW'(16 * wr);
                    n_checks++; if (mem_addr !== ea) begin n_fail++; $display("FAIL %s mem_addr beat %0d: got %h want %h", tag, wr, mem_addr, ea); end
                    n_checks++; if (mem_wdata !== d[wr]) begin n_fail++; $display("FAIL %s mem_wdata beat %0d: got %h want %h", tag, wr, mem_wdata, d[wr]); end
                end
                if (stall) begin
                    n_checks++; if (mem_addr !== pa || mem_wdata !== pd) begin n_fail++; $display("FAIL %s hold_stable cyc %0d: got %h want %h", tag, cyc, mem_addr, pa); end
                end
                push = st_valid && exp_ready;
                pop  = mem_ack && exp_req;
                if (st_valid && !exp_ready) err_exp = 1'b1;
                stall = exp_req && !mem_ack;
                pa = mem_addr; pd = mem_wdata;
                acc += int'(push);
                wr += int'(pop);
                outst = outst + int'(push) - int'(pop);
                if (abort_at >= 0 && wr == abort_at) begin
                    @(posedge clk); #2;
                    nrst = 1'b1;
                    #1;
                    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s abort_req: got %b want 0", tag, mem_req); end
                    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s abort_busy: got %b want 0", tag, busy); end
                    n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL %s abort_ready: got %b want 0", tag, st_ready); end
                    @(negedge clk);
                    st_valid = 1'b0; mem_ack = 1'b0; nrst = 1'b0; err_exp = 1'b0;
                    repeat (3) begin
                        @(negedge clk); #1;
                        n_checks++; if (s_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s abort_no_done: got s_done=%b busy=%b want 0 0", tag, s_done, busy); end
                    end
                    fin = 1'b1;
                end
                if (!fin) @(negedge clk);
                cyc++;
            end
        end
        if (!fin) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: got %0d writes want %0d", tag, wr, nb);
        end
        st_valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 nrst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s); #1;
            n_checks++;
            if ({st_ready, mem_req, busy, s_done, err} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs sel %0d: got %b %h %h want all 0", s, {st_ready, mem_req, busy, s_done, err}, mem_addr, mem_wdata);
            end
        end
        sel = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_store(32'h0000_1000, 8, 100, 100, 0, -1, 0, -1, "basic");
    endtask

    task automatic test_ack_hold();
        run_store(32'h0000_4000, 8, 100, 100, 0, 3, 0, -1, "ack_hold");
    endtask

    task automatic test_backpressure();
        sel = 1'b1;
        apply_reset();
        run_store(32'h0000_0000, 16, 100, 100, 30, -1, 0, -1, "backpressure16");
        sel = 1'b0;
        apply_reset();
    endtask

    task automatic test_drop();
        #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL drop_err_before: got %b want 0", err); end
        @(negedge clk);
        st_valid = 1'b1; st_data = {4{$urandom}};
        @(negedge clk);
        st_valid = 1'b0; err_exp = 1'b1;
        #1;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL drop_idle_err: got %b want 1", err); end
        run_store(32'h0000_3000, 8, 100, 70, 0, -1, 1, -1, "drop_extra");
        #1;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL drop_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        run_store(32'h0000_5000, 8, 100, 60, 0, -1, 0, 4, "abort");
        run_store(32'h0000_2000, 8, 80, 80, 0, -1, 0, -1, "after_abort");
    endtask

    task automatic test_back_to_back();
        run_store({$urandom_range(32'hFFFF), 4'h0}, 8, $urandom_range(50, 90), $urandom_range(40, 90), 0, -1, 0, -1, "b2b_0");
        run_store({$urandom, 4'h0} & 32'hFFFF_FFF0, 8, $urandom_range(50, 90), $urandom_range(40, 90), 0, -1, 0, -1, "b2b_1");
        run_store(32'hFFFF_FFC0, 8, $urandom_range(50, 90), $urandom_range(40, 90), 0, -1, 0, -1, "b2b_wrap");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_hold();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
